carry_lookahead_adder: RTL and testbench

- Registered, parameterisable carry-lookahead adder computing s/cout = a + b + cin.
- Built from 4-bit lookahead groups, each exporting group propagate/generate.
- A second-level lookahead unit forms the inter-group carries, so there is no ripple between groups.
- A one-cycle registered output stage lets the adder sit as a pipeline stage on the arithmetic datapath.

---
 rtl/cla_pkg.sv | 8 +
 rtl/cla_group4.sv | 23 ++
 rtl/carry_lookahead_adder.sv | 68 ++++++
 tb/tb_carry_lookahead_adder.sv | 118 +++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the carry-lookahead adder.
package cla_pkg;
    localparam int CLA_GROUP_W = 4;

    function automatic int cla_groups(input int width);
        return width / CLA_GROUP_W;
    endfunction
endpackage

// File: rtl/cla_group4.sv
// cla_group4: 4-bit lookahead group producing sum bits and group propagate/generate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] a,
    input  logic [CLA_GROUP_W-1:0] b,
    input  logic                   c_in,
    output logic [CLA_GROUP_W-1:0] s,
    output logic                   grp_p,
    output logic                   grp_g
);
    logic [CLA_GROUP_W-1:0] p, g, c;

    assign p = a ^ b;
    assign g = a & b;
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    assign s = p ^ c;
    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: two-level carry-lookahead adder with a one-cycle registered output.
module carry_lookahead_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
);
    localparam int N = cla_groups(WIDTH);

    if ((WIDTH % CLA_GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("carry_lookahead_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    logic [N-1:0]     grp_p, grp_g;
    logic [N:0]       c;
    logic [WIDTH-1:0] sum;

    assign c[0] = cin;

    for (genvar k = 0; k < N; k++) begin : g_grp
        cla_group4 u_grp (
            .a    (a[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .b    (b[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .c_in (c[k]),
            .s    (sum[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .grp_p(grp_p[k]),
            .grp_g(grp_g[k])
        );
    end

    // Each group carry is a flat OR of product terms straight from P/G/cin,
    // so no group waits on the carry of the group below it.
    for (genvar k = 0; k < N; k++) begin : g_carry
        logic [k+1:0] t;
        assign t[0] = cin & (&grp_p[k:0]);
        for (genvar j = 0; j <= k; j++) begin : g_term
            if (j < k) begin : g_mid
                assign t[j+1] = grp_g[j] & (&grp_p[k:j+1]);
            end else begin : g_top
                assign t[j+1] = grp_g[j];
            end
        end
        assign c[k+1] = |t;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= sum;
                cout <= c[N];
            end
        end
    end
endmodule

// File: tb/tb_carry_lookahead_adder.sv
// tb_carry_lookahead_adder: checks 4/16/32-bit adders against an arithmetic reference model.
module tb_carry_lookahead_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0;

    logic [3:0]  s4;
    logic [15:0] s16;
    logic [31:0] s32;
    logic        c4, c16, c32, v4, v16, v32;

    int compared = 0;
    int mismatched = 0;

    logic [32:0] exp_sum [3];
    logic        exp_valid = 1'b0;

    always #5 clk = ~clk;

    carry_lookahead_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[3:0]), .b(b[3:0]), .cin(cin),
        .s(s4), .cout(c4), .out_valid(v4)
    );
    carry_lookahead_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[15:0]), .b(b[15:0]), .cin(cin),
        .s(s16), .cout(c16), .out_valid(v16)
    );
    carry_lookahead_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .s(s32), .cout(c32), .out_valid(v32)
    );

    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic ci, input int w);
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        return ((({1'b0, x} & m) + ({1'b0, y} & m) + {32'd0, ci}) & ((m << 1) | 33'd1));
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("sum4",   {28'd0, c4, s4},   exp_sum[0]);
        chk("sum16",  {16'd0, c16, s16}, exp_sum[1]);
        chk("sum32",  {c32, s32},        exp_sum[2]);
        chk("valid4", {32'd0, v4},       {32'd0, exp_valid});
        chk("valid16",{32'd0, v16},      {32'd0, exp_valid});
        chk("valid32",{32'd0, v32},      {32'd0, exp_valid});
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] aa,
                        input logic [31:0] bb, input logic ci);
        rst = r;
        in_valid = v;
        a = aa;
        b = bb;
        cin = ci;
        @(posedge clk);
        if (r) begin
            foreach (exp_sum[i]) exp_sum[i] = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = v;
            if (v) begin
                exp_sum[0] = ref_add(aa, bb, ci, 4);
                exp_sum[1] = ref_add(aa, bb, ci, 16);
                exp_sum[2] = ref_add(aa, bb, ci, 32);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] r1, r2;
        foreach (exp_sum[i]) exp_sum[i] = '0;
        @(negedge clk);
        step(1'b1, 1'b1, $urandom, $urandom, 1'b1);
        step(1'b1, 1'b1, $urandom, $urandom, 1'b0);
        step(1'b0, 1'b1, 32'h3, 32'hC, 1'b0);
        chk("release_s4", {29'd0, s4}, 33'hF);
        step(1'b0, 1'b1, 32'h0, 32'hF, 1'b0);
        step(1'b0, 1'b1, 32'h5, 32'hC, 1'b0);
        chk("wrap_s4", {28'd0, c4, s4}, 33'h11);
        step(1'b0, 1'b1, 32'hA, 32'hD, 1'b1);
        chk("cin_s4", {28'd0, c4, s4}, 33'h18);
        step(1'b0, 1'b1, 32'h7, 32'hB, 1'b1);
        step(1'b0, 1'b1, 32'h8, 32'h9, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        chk("prop_s16", {16'd0, c16, s16}, 33'h1_0000);
        chk("prop_s32", {c32, s32}, 33'h1_0000_0000);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("ones_s32", {c32, s32}, 33'h1_FFFF_FFFF);
        step(1'b0, 1'b1, 32'h3, 32'h4, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $urandom, $urandom, 1'b1);
        chk("hold_s4", {28'd0, c4, s4}, 33'h7);
        step(1'b0, 1'b1, $urandom, $urandom, 1'b1);
        step(1'b1, 1'b1, $urandom, $urandom, 1'b1);
        for (int x = 0; x < 512; x++) begin
            r1 = $urandom;
            r2 = $urandom;
            step(1'b0, 1'b1, {r1[31:4], 4'(x)}, {r2[31:4], 4'(x >> 4)}, x[8]);
        end
        for (int i = 0; i < 10000; i++) begin
            step(1'b0, ($urandom_range(0, 7) != 0), $urandom, $urandom, 1'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
